// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection pipeline.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WIN_SIZE = 3;

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/column position counter; advances one pixel per advance pulse.
module raster_counter #(
  parameter int WIDTH  = 540,
  parameter int HEIGHT = 405
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      advance,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic                      last
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance) begin
      if (w_col_last) begin
        r_col <= '0;
        // Wrap the row too so the counter is frame-aligned even without clear.
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = w_row_last && w_col_last;

endmodule

// File: rtl/window_ctrl.sv
// Line-buffer sequencer: accepts raster pixels, drives the 3x3 shift register
// and flags complete in-image windows, holding them under backpressure.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// Input side: in_valid/in_ready, a transfer is shift_en. Output side:
// win_valid/win_ready; win_valid, win_row and win_col hold stable until taken.
module window_ctrl
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH  = 540,
  parameter int IMG_HEIGHT = 405
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [7:0]                    in_pixel,
  output logic                          in_ready,
  output logic                          shift_en,
  output logic [7:0]                    pixel_in,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          busy,
  output logic                          frame_done,
  output state_t                        dbg_state
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_MIN = RW'(WIN_SIZE - 1);
  localparam logic [CW-1:0] COL_MIN = CW'(WIN_SIZE - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          w_in_ready;
  logic          w_shift_en;
  logic          w_clear;
  logic          w_consume;
  logic          w_completes;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_last;

  logic          r_win_valid;
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;
  logic          r_frame_done;

  raster_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT)
  ) u_raster_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_clear),
    .advance (w_shift_en),
    .row     (w_row),
    .col     (w_col),
    .last    (w_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_in_ready = !r_win_valid || win_ready;
        if (in_valid && w_in_ready && w_last) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (r_win_valid && win_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_shift_en  = in_valid && w_in_ready;
  assign w_consume   = r_win_valid && win_ready;
  // Columns 0-1 are excluded so a window never straddles a row wrap.
  assign w_completes = (w_row >= ROW_MIN) && (w_col >= COL_MIN);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else if (w_shift_en && w_completes) begin
      r_win_valid <= 1'b1;
      r_win_row   <= w_row - RW'(1);
      r_win_col   <= w_col - CW'(1);
    end else if (w_consume) begin
      r_win_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == DRAIN) && w_consume;
    end
  end

  assign in_ready   = w_in_ready;
  assign shift_en   = w_shift_en;
  assign pixel_in   = in_pixel;
  assign win_valid  = r_win_valid;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: doc/window_ctrl.md
# window_ctrl

Sequencer for the 3x3 line-buffer shift register in the edge-detection pipeline. Accepts a raster-order pixel stream with valid/ready handshaking and drives the line buffer's shift enable and pixel input. Tracks row/column position and flags when the buffer holds a complete, in-image 3x3 window, holding it under downstream backpressure. Sits between the pixel source and the shift register / Sobel kernel pair at the top level.

## Interface
- IMG_WIDTH, 540, pixels per row; must equal the line buffer's IMG_WIDTH; minimum 3
- IMG_HEIGHT, 405, rows per frame; minimum 3
- clock  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high; also drives the line buffer's reset at top level
- start  input  1  one-cycle pulse, begins a frame; honoured only in IDLE
- in_valid  input  1  source has a pixel
- in_pixel  input  8  source pixel
- in_ready  output  1  controller accepts in_pixel this cycle
- shift_en  output  1  to line buffer; equals in_valid & in_ready
- pixel_in  output  8  to line buffer; combinational copy of in_pixel
- win_valid  output  1  line buffer outputs form a valid window
- win_ready  input  1  kernel consumes window this cycle
- win_row  output  $clog2(IMG_HEIGHT)  centre row of current window
- win_col  output  $clog2(IMG_WIDTH)  centre column of current window
- busy  output  1  high in RUN and DRAIN
- frame_done  output  1  one-cycle pulse when the last window is consumed

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. start → RUN; row and col cleared to 0.
- RUN: in_ready = !win_valid | win_ready. Each accepted pixel (shift_en=1) is at (row, col); col increments, wrapping to 0 at IMG_WIDTH-1 with row incrementing.
- Accepted pixel with row≥2 and col≥2: win_valid set next cycle, win_row=row-1, win_col=col-1, all registered. Otherwise win_valid cleared next cycle if currently consumed.
- Columns 0–1 of every row never produce a window: row wrap-around suppresses windows straddling rows.
- Last pixel accepted at (IMG_HEIGHT-1, IMG_WIDTH-1) → DRAIN.
- DRAIN: in_ready=0. When win_valid & win_ready: frame_done pulses next cycle and the state goes to IDLE.
- Window count per frame is exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- start in RUN or DRAIN is ignored. in_valid gaps are legal and do not advance the counters.
- The line buffer is not cleared between frames. Stale contents are harmless because the first window of every frame requires two fresh rows.

## Timing
- Reset values: state IDLE, row=col=0, in_ready=0, shift_en=0, win_valid=0, win_row=win_col=0, busy=0, frame_done=0.
- The line buffer updates on the same edge that the controller registers win_valid. The window is therefore presented 1 cycle after the accept of its bottom-right pixel.
- Throughput is 1 pixel per cycle with win_ready held high.
- Simultaneous consume and accept: when win_valid & win_ready & in_valid, a new pixel is accepted in the same cycle. win_valid stays high if the new pixel completes a window.
- Backpressure: win_valid high with win_ready low forces in_ready=0, so shift_en=0 and the window holds stable.
- Reset mid-frame takes effect on the next edge and returns to IDLE with all outputs at reset values. There is no partial frame_done.
- in_ready depends combinationally on win_ready. shift_en and pixel_in depend combinationally on in_valid and in_pixel.

## Structure
- Shared package edge_pkg holds:
  - the state typedef: enum logic [1:0] {IDLE, RUN, DRAIN}
  - the constant WIN_SIZE=3
- Sub-module raster_counter (parameters WIDTH, HEIGHT):
  - inputs: clear, advance
  - outputs: row, col, last (high at the final pixel)
- Controller is FSM plus window-register logic, around 150–250 lines total.
- The controller does not instantiate the line buffer; the top level connects the two.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 streamed with in_valid and win_ready held high → exactly 4 windows with (win_row, win_col) = (1,1), (1,2), (2,1), (2,2). The first win_valid is 1 cycle after pixel 10 is accepted. frame_done pulses once, after the cycle in which the final window is consumed.
- Same frame, win_ready low for 5 cycles at the first window → in_ready=0 and shift_en=0 throughout, window taps unchanged, pixel 11 accepted in the cycle win_ready returns high.
- Random in_valid gaps of about 50% duty, 5x3 image → 3 windows with centres (1,1), (1,2), (1,3), in order, none lost or duplicated.
- Reset asserted after pixel 7 of a 4x4 frame → next cycle state IDLE and all outputs zero. A new start plus 16 pixels yields 4 correct windows.
- start pulsed during RUN and during DRAIN → no effect on counters. Only one frame_done per frame.
- Two back-to-back 4x4 frames, start issued in the cycle after frame_done → second frame produces 4 windows whose centres match the first frame.
